// File: rtl/sync_serial_rx.sv
// Synchronous serial receiver: start, DATA_W data bits LSB first,
// optional parity, one stop bit; word out on valid/ready with error flags.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous reset, active-low
//   bit_en     sample strobe; D used only when 1
//   D          serial line, idle 1, start 0
//   data_out   received word, stable while valid
//   valid      data_out holds a word not yet taken
//   ready      consumer takes word when valid & ready
//   parity_err parity mismatch for word in data_out
//   frame_err  1-cycle pulse, stop bit sampled 0
//   overrun    1-cycle pulse, word completed while output full
//   busy       receiver not idle
module sync_serial_rx #(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_en,
   input  logic              D,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   input  logic              ready,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              pbit_q, pbit_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;
   logic              ovr_q, ovr_d;
   logic              stop_stb;
   logic              perr_calc;

   // Even parity: XOR of data and parity bit must equal PARITY_ODD.
   always_comb begin
      perr_calc = 1'b0;
      if (PARITY_EN != 0)
         perr_calc = (^{shift_q, pbit_q}) != PARITY_ODD[0];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      pbit_d   = pbit_q;
      stop_stb = 1'b0;
      if (bit_en) begin
         unique case (state_q)
            IDLE: begin
               if (!D) begin
                  state_d = DATA;
                  cnt_d   = '0;
               end
            end
            DATA: begin
               // LSB arrives first, so shift toward bit 0.
               shift_d = shift_q >> 1;
               shift_d[DATA_W-1] = D;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
            PARITY: begin
               pbit_d  = D;
               state_d = STOP;
            end
            STOP: begin
               stop_stb = 1'b1;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      if (valid_q && ready) begin
         valid_d = 1'b0;
         perr_d  = 1'b0;
      end
      if (stop_stb) begin
         if (!D) begin
            ferr_d = 1'b1;
         end else if (!valid_q || ready) begin
            // Slot is free, or is being freed on this same edge.
            data_d  = shift_q;
            perr_d  = perr_calc;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         pbit_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         pbit_q  <= pbit_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_out   = data_q;
   assign valid      = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sync_serial_rx.sv
// Directed bench for sync_serial_rx (8 data bits, even parity).
// Table of whole frames plus hand-written corner sequences.
module tb_sync_serial_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       bit_en;
   logic       D;
   logic [7:0] data_out;
   logic       valid;
   logic       ready;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;
   logic valid_before_stop;

   sync_serial_rx #(
      .DATA_W(8),
      .PARITY_EN(1),
      .PARITY_ODD(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bit_en(bit_en),
      .D(D),
      .data_out(data_out),
      .valid(valid),
      .ready(ready),
      .parity_err(parity_err),
      .frame_err(frame_err),
      .overrun(overrun),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       s;
      logic       ev;
      logic       ep;
      logic       ef;
   } vec_t;

   vec_t tbl[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // bit_en held high; ready only driven during the stop-bit cycle.
   task automatic send_frame(input logic [7:0] d,
                             input logic p,
                             input logic s,
                             input logic rdy_stop);
      bit_en = 1'b1;
      ready  = 1'b0;
      D      = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         D = d[i];
         step();
      end
      D = p;
      step();
      valid_before_stop = valid;
      D     = s;
      ready = rdy_stop;
      step();
      ready = 1'b0;
      D     = 1'b1;
   endtask

   // One strobe every 4th clock, D toggled on the idle clocks.
   task automatic send_slow(input logic [7:0] d,
                            input logic p,
                            input logic s);
      logic [10:0] bits;
      bits = {s, p, d, 1'b0};
      ready = 1'b0;
      for (int k = 0; k < 11; k++) begin
         bit_en = 1'b1;
         D = bits[k];
         step();
         for (int j = 0; j < 3; j++) begin
            bit_en = 1'b0;
            D = ~D;
            step();
         end
      end
   endtask

   task automatic consume();
      ready = 1'b1;
      step();
      ready = 1'b0;
   endtask

   initial begin
      tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{8'h7E, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      rst    = 1'b0;
      bit_en = 1'b0;
      D      = 1'b1;
      ready  = 1'b0;
      step();
      step();
      rst = 1'b1;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flags", 32'({parity_err, frame_err, overrun}), 32'd0);

      // Reset mid-frame with a word already held.
      send_frame(8'h33, 1'b0, 1'b1, 1'b0);
      chk("t1_pre_valid", 32'(valid), 32'd1);
      chk("t1_pre_data", 32'(data_out), 32'h33);
      D = 1'b0;
      step();
      D = 1'b1;
      step();
      D = 1'b0;
      step();
      chk("t1_busy_mid", 32'(busy), 32'd1);
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      D   = 1'b1;
      chk("t1_valid", 32'(valid), 32'd0);
      chk("t1_data", 32'(data_out), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_flags", 32'({parity_err, frame_err, overrun}), 32'd0);
      step();
      chk("t1_idle_busy", 32'(busy), 32'd0);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      chk("t1_5a_valid", 32'(valid), 32'd1);
      chk("t1_5a_data", 32'(data_out), 32'h5A);
      chk("t1_5a_perr", 32'(parity_err), 32'd0);
      consume();
      chk("t1_consumed", 32'(valid), 32'd0);

      // Latency and hold.
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      chk("t2_lat_before", 32'(valid_before_stop), 32'd0);
      chk("t2_valid", 32'(valid), 32'd1);
      chk("t2_data", 32'(data_out), 32'hA5);
      chk("t2_perr", 32'(parity_err), 32'd0);
      chk("t2_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t2_hold_valid", 32'(valid), 32'd1);
         chk("t2_hold_data", 32'(data_out), 32'hA5);
      end
      consume();
      chk("t2_taken", 32'(valid), 32'd0);
      step();
      chk("t2_stay0", 32'(valid), 32'd0);

      // Table of frames, each consumed after checking.
      for (int i = 0; i < 8; i++) begin
         send_frame(tbl[i].d, tbl[i].p, tbl[i].s, 1'b0);
         chk("tbl_valid", 32'(valid), 32'(tbl[i].ev));
         chk("tbl_ferr", 32'(frame_err), 32'(tbl[i].ef));
         chk("tbl_ovr", 32'(overrun), 32'd0);
         if (tbl[i].ev) begin
            chk("tbl_data", 32'(data_out), 32'(tbl[i].d));
            chk("tbl_perr", 32'(parity_err), 32'(tbl[i].ep));
         end
         step();
         chk("tbl_ferr_1clk", 32'(frame_err), 32'd0);
         consume();
         chk("tbl_taken", 32'(valid), 32'd0);
         chk("tbl_perr_clr", 32'(parity_err), 32'd0);
      end

      // Overrun: second word dropped, first held.
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
      chk("t5_first", 32'(data_out), 32'h3C);
      send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
      chk("t5_ovr", 32'(overrun), 32'd1);
      chk("t5_ovr_ferr", 32'(frame_err), 32'd0);
      chk("t5_held", 32'(data_out), 32'h3C);
      chk("t5_held_v", 32'(valid), 32'd1);
      step();
      chk("t5_ovr_1clk", 32'(overrun), 32'd0);
      consume();
      chk("t5_taken", 32'(valid), 32'd0);

      // Take and load on the same edge.
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
      send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
      chk("t5b_data", 32'(data_out), 32'hC3);
      chk("t5b_valid", 32'(valid), 32'd1);
      chk("t5b_ovr", 32'(overrun), 32'd0);
      step();
      chk("t5b_ovr2", 32'(overrun), 32'd0);
      chk("t5b_hold", 32'(valid), 32'd1);
      consume();
      chk("t5b_taken", 32'(valid), 32'd0);

      // Sparse strobes.
      send_slow(8'h81, 1'b0, 1'b1);
      chk("t6_valid", 32'(valid), 32'd1);
      chk("t6_data", 32'(data_out), 32'h81);
      chk("t6_flags", 32'({parity_err, frame_err, overrun}), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      consume();
      chk("t6_taken", 32'(valid), 32'd0);
      bit_en = 1'b0;
      D = 1'b0;
      step();
      step();
      chk("t6_noen_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
